// File: rtl/ntt_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_feeder
//  Purpose  : Buffers one Kyber polynomial from a valid/ready stream, then
//             feeds butterfly operand pairs (NTT or INTT order) followed by
//             zero-valued flush pairs into the first NTT pipeline stage.
//  Revision : 1.0  initial release
// ============================================================================
module ntt_feeder #(
    parameter int N            = 256,
    parameter int W            = 12,
    parameter int Q            = 3329,
    parameter int FLUSH_CYCLES = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         pipe_hold,
    output logic         pipe_en,
    output logic [W-1:0] o1,
    output logic [W-1:0] o2,
    output logic         busy,
    output logic         done
);

    localparam int AW    = $clog2(N);
    localparam int KW    = AW - 1;
    localparam int HALF  = N / 2;
    localparam int TOTAL = HALF + FLUSH_CYCLES;
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [W-1:0]  C_Q         = W'(Q);
    localparam logic [AW-1:0] C_LAST_WR   = AW'(N - 1);
    localparam logic [CW-1:0] C_HALF      = CW'(HALF);
    localparam logic [CW-1:0] C_TOTAL     = CW'(TOTAL);
    localparam logic [CW-1:0] C_LAST_DATA = CW'(HALF - 1);
    localparam logic [CW-1:0] C_LAST_ITEM = CW'(TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_mode;
    logic [AW-1:0]  r_wr_cnt;
    logic [CW-1:0]  r_iss_cnt;
    logic [CW-1:0]  r_out_cnt;

    logic [W-1:0]   r_mem [N];
    logic [W-1:0]   r_rd1;
    logic [W-1:0]   r_rd2;
    logic           r_rd_v;
    logic           r_rd_z;

    logic           r_sk_v;
    logic [W-1:0]   r_sk1;
    logic [W-1:0]   r_sk2;

    logic           r_pipe_en;
    logic [W-1:0]   r_o1;
    logic [W-1:0]   r_o2;
    logic           r_done;

    logic           w_hs;
    logic [W-1:0]   w_wdata;
    logic           w_more;
    logic           w_take;
    logic           w_issue;
    logic           w_is_data;
    logic [KW-1:0]  w_k;
    logic [AW-1:0]  w_a1;
    logic [AW-1:0]  w_a2;
    logic [W-1:0]   w_rd1;
    logic [W-1:0]   w_rd2;

    assign in_ready = (r_state == S_LOAD);
    assign busy     = (r_state != S_IDLE);
    assign pipe_en  = r_pipe_en;
    assign o1       = r_o1;
    assign o2       = r_o2;
    assign done     = r_done;

    always_comb begin
        w_hs      = in_valid && in_ready;
        w_wdata   = (in_data >= C_Q) ? (in_data - C_Q) : in_data;
        w_more    = ((r_state == S_STREAM) || (r_state == S_FLUSH)) && (r_iss_cnt != C_TOTAL);
        w_take    = !pipe_hold && (r_sk_v || r_rd_v);
        // A new fetch is allowed whenever the read register will be vacated.
        w_issue   = w_more && (!r_rd_v || !r_sk_v || w_take);
        w_is_data = (r_iss_cnt < C_HALF);
        w_k       = r_iss_cnt[KW-1:0];
        w_a1      = r_mode ? {w_k, 1'b0} : {1'b0, w_k};
        w_a2      = r_mode ? {w_k, 1'b1} : {1'b1, w_k};
        w_rd1     = r_rd_z ? '0 : r_rd1;
        w_rd2     = r_rd_z ? '0 : r_rd2;
    end

    // Coefficient buffer: no reset, synchronous read with enable.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_mem[r_wr_cnt] <= w_wdata;
        end
        if (w_issue && w_is_data) begin
            r_rd1 <= r_mem[w_a1];
            r_rd2 <= r_mem[w_a2];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_wr_cnt  <= '0;
            r_iss_cnt <= '0;
            r_out_cnt <= '0;
            r_rd_v    <= 1'b0;
            r_rd_z    <= 1'b0;
            r_sk_v    <= 1'b0;
            r_sk1     <= '0;
            r_sk2     <= '0;
            r_pipe_en <= 1'b0;
            r_o1      <= '0;
            r_o2      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_pipe_en <= w_take;
            if (w_take) begin
                r_o1 <= r_sk_v ? r_sk1 : w_rd1;
                r_o2 <= r_sk_v ? r_sk2 : w_rd2;
            end

            // Skid register parks the fetched pair while the output is stalled.
            if (r_sk_v) begin
                if (w_take) begin
                    r_sk_v <= r_rd_v;
                    r_sk1  <= w_rd1;
                    r_sk2  <= w_rd2;
                end
            end else if (r_rd_v && !w_take) begin
                r_sk_v <= 1'b1;
                r_sk1  <= w_rd1;
                r_sk2  <= w_rd2;
            end

            if (w_issue) begin
                r_rd_v    <= 1'b1;
                r_rd_z    <= !w_is_data;
                r_iss_cnt <= r_iss_cnt + 1'b1;
            end else if (!r_sk_v || w_take) begin
                r_rd_v <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode    <= mode;
                        r_state   <= S_LOAD;
                        r_wr_cnt  <= '0;
                        r_iss_cnt <= '0;
                        r_out_cnt <= '0;
                        r_o1      <= '0;
                        r_o2      <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                        if (r_wr_cnt == C_LAST_WR) begin
                            r_state   <= S_STREAM;
                            r_iss_cnt <= '0;
                        end
                    end
                end
                S_STREAM, S_FLUSH: begin
                    // Phase changes are driven by delivered pairs, not fetches.
                    if (r_pipe_en) begin
                        r_out_cnt <= r_out_cnt + 1'b1;
                        if (r_out_cnt == C_LAST_ITEM) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else if ((r_state == S_STREAM) && (r_out_cnt == C_LAST_DATA)) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntt_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntt_feeder
//  Purpose  : Directed self-checking bench for ntt_feeder.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ntt_feeder;

    localparam int N     = 256;
    localparam int W     = 12;
    localparam int Q     = 3329;
    localparam int FL    = 128;
    localparam int HALF  = N / 2;
    localparam int TOTAL = HALF + FL;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         pipe_hold = 1'b0;
    logic         in_ready;
    logic         pipe_en;
    logic [W-1:0] o1;
    logic [W-1:0] o2;
    logic         busy;
    logic         done;

    ntt_feeder #(.N(N), .W(W), .Q(Q), .FLUSH_CYCLES(FL)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .pipe_hold (pipe_hold),
        .pipe_en   (pipe_en),
        .o1        (o1),
        .o2        (o2),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int ld_val [N];
    int cap1 [512];
    int cap2 [512];
    int en_cnt, hs_cnt, done_cnt, done_rel, first_en_rel;
    int hold_viol, pre_nz, rdy_viol, busy_at_done, late_busy, ab_hit;
    logic         ab_en, ab_busy, ab_done, ab_rdy;
    logic [W-1:0] ab_o1, ab_o2;

    function automatic int red(input int x);
        return (x >= Q) ? x - Q : x;
    endfunction

    // Runs one job: start, load ld_val[], then observe the stream until done.
    task automatic run_job(input logic m, input bit gaps, input bit noisy,
                           input int hk1, input int hk2, input int abort_k);
        int idx, cyc, rel, hold_rem, tail;
        bit seen_en, seen_done, prev_hold;
        logic [W-1:0] p1, p2;
        for (int i = 0; i < 512; i++) begin
            cap1[i] = -1;
            cap2[i] = -1;
        end
        en_cnt = 0; hs_cnt = 0; done_cnt = 0; done_rel = -1; first_en_rel = -1;
        hold_viol = 0; pre_nz = 0; rdy_viol = 0; busy_at_done = -1; late_busy = 0; ab_hit = 0;
        seen_en = 0; seen_done = 0; prev_hold = 0; hold_rem = 0; tail = 0;
        p1 = '0; p2 = '0;
        @(negedge clk);
        start = 1'b1; mode = m; pipe_hold = 1'b0;
        @(negedge clk);
        start = 1'b0; mode = noisy ? ~m : m;
        idx = 0; cyc = 0;
        while (idx < N && cyc < 3000) begin
            if (pipe_en || o1 != 0 || o2 != 0) pre_nz++;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = W'(ld_val[idx]);
            start    = noisy && ($urandom_range(0, 5) == 0);
            if (in_valid && in_ready) begin
                idx++;
                hs_cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        rel = 0;
        in_valid = 1'b1;
        in_data  = 12'habc;
        while (tail < 4 && rel < 3000) begin
            start = 1'b0;
            if (in_ready) rdy_viol++;
            if (in_valid && in_ready) hs_cnt++;
            if (prev_hold && (pipe_en || o1 != p1 || o2 != p2)) hold_viol++;
            if (!seen_en && !pipe_en && (o1 != 0 || o2 != 0)) pre_nz++;
            if (done) begin
                done_cnt++;
                if (!seen_done) begin
                    done_rel = rel;
                    busy_at_done = int'(busy);
                end
                seen_done = 1;
            end else if (seen_done && busy) begin
                late_busy++;
            end
            if (pipe_en) begin
                if (!seen_en) first_en_rel = rel;
                seen_en = 1;
                if (en_cnt < 512) begin
                    cap1[en_cnt] = int'(o1);
                    cap2[en_cnt] = int'(o2);
                end
                if (en_cnt == abort_k) begin
                    rst = 1'b0;
                    #1;
                    ab_en = pipe_en; ab_o1 = o1; ab_o2 = o2;
                    ab_busy = busy; ab_done = done; ab_rdy = in_ready;
                    ab_hit = 1;
                    return;
                end
                if (en_cnt == hk1 || en_cnt == hk2) hold_rem = 5;
                en_cnt++;
            end
            p1 = o1; p2 = o2;
            pipe_hold = (hold_rem > 0);
            prev_hold = pipe_hold;
            if (hold_rem > 0) hold_rem--;
            if (noisy && !seen_done) start = ($urandom_range(0, 5) == 0);
            if (seen_done) tail++;
            @(negedge clk);
            rel++;
        end
        in_valid = 1'b0; pipe_hold = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, pipe_en, busy, done} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/en/busy/done=%b want 0000", {in_ready, pipe_en, busy, done});
        end
        n_checks++;
        if (o1 !== '0 || o2 !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got (%0d,%0d) want (0,0)", o1, o2);
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b rdy=%b want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_ntt_order();
        int e1, e2;
        for (int j = 0; j < N; j++) ld_val[j] = j;
        run_job(1'b0, 0, 0, -1, -1, -1);
        n_checks++;
        if (hs_cnt != N) begin n_fail++; $display("FAIL ntt_handshakes: got %0d want %0d", hs_cnt, N); end
        n_checks++;
        if (en_cnt != TOTAL) begin n_fail++; $display("FAIL ntt_en_count: got %0d want %0d", en_cnt, TOTAL); end
        n_checks++;
        if (first_en_rel != 2) begin n_fail++; $display("FAIL ntt_first_en: got %0d want 2", first_en_rel); end
        for (int k = 0; k < TOTAL; k++) begin
            e1 = (k < HALF) ? k : 0;
            e2 = (k < HALF) ? k + HALF : 0;
            n_checks++;
            if (cap1[k] != e1 || cap2[k] != e2) begin
                n_fail++;
                $display("FAIL ntt_pair[%0d]: got (%0d,%0d) want (%0d,%0d)", k, cap1[k], cap2[k], e1, e2);
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_rel != 2 + TOTAL) begin
            n_fail++;
            $display("FAIL ntt_done: got count=%0d at=%0d want count=1 at=%0d", done_cnt, done_rel, 2 + TOTAL);
        end
        n_checks++;
        if (busy_at_done != 0 || late_busy != 0) begin
            n_fail++;
            $display("FAIL ntt_busy: got at_done=%0d late=%0d want 0 0", busy_at_done, late_busy);
        end
        n_checks++;
        if (pre_nz != 0 || rdy_viol != 0) begin
            n_fail++;
            $display("FAIL ntt_idle_outputs: got prenz=%0d rdy=%0d want 0 0", pre_nz, rdy_viol);
        end
    endtask

    task automatic test_intt_order();
        int e1, e2;
        for (int j = 0; j < N; j++) ld_val[j] = j;
        run_job(1'b1, 0, 0, -1, -1, -1);
        n_checks++;
        if (en_cnt != TOTAL) begin n_fail++; $display("FAIL intt_en_count: got %0d want %0d", en_cnt, TOTAL); end
        for (int k = 0; k < TOTAL; k++) begin
            e1 = (k < HALF) ? 2 * k : 0;
            e2 = (k < HALF) ? 2 * k + 1 : 0;
            n_checks++;
            if (cap1[k] != e1 || cap2[k] != e2) begin
                n_fail++;
                $display("FAIL intt_pair[%0d]: got (%0d,%0d) want (%0d,%0d)", k, cap1[k], cap2[k], e1, e2);
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_rel != 2 + TOTAL) begin
            n_fail++;
            $display("FAIL intt_done: got count=%0d at=%0d want 1 at %0d", done_cnt, done_rel, 2 + TOTAL);
        end
    endtask

    task automatic test_reduction();
        for (int j = 0; j < N; j++) ld_val[j] = 0;
        ld_val[0] = 3328;
        ld_val[1] = 3329;
        ld_val[2] = 4095;
        run_job(1'b1, 0, 0, -1, -1, -1);
        n_checks++;
        if (cap1[0] != 3328 || cap2[0] != 0) begin
            n_fail++;
            $display("FAIL red_pair0: got (%0d,%0d) want (3328,0)", cap1[0], cap2[0]);
        end
        n_checks++;
        if (cap1[1] != 766 || cap2[1] != 0) begin
            n_fail++;
            $display("FAIL red_pair1: got (%0d,%0d) want (766,0)", cap1[1], cap2[1]);
        end
        n_checks++;
        if (cap1[2] != 0 || cap2[2] != 0 || en_cnt != TOTAL) begin
            n_fail++;
            $display("FAIL red_rest: got pair2=(%0d,%0d) en=%0d want (0,0) en=%0d", cap1[2], cap2[2], en_cnt, TOTAL);
        end
    endtask

    task automatic test_hold();
        int e1, e2;
        for (int j = 0; j < N; j++) ld_val[j] = j;
        run_job(1'b0, 0, 0, 40, HALF + 50, -1);
        n_checks++;
        if (en_cnt != TOTAL) begin n_fail++; $display("FAIL hold_en_count: got %0d want %0d", en_cnt, TOTAL); end
        n_checks++;
        if (hold_viol != 0) begin n_fail++; $display("FAIL hold_stall: got %0d violations want 0", hold_viol); end
        for (int k = 0; k < TOTAL; k++) begin
            e1 = (k < HALF) ? k : 0;
            e2 = (k < HALF) ? k + HALF : 0;
            n_checks++;
            if (cap1[k] != e1 || cap2[k] != e2) begin
                n_fail++;
                $display("FAIL hold_pair[%0d]: got (%0d,%0d) want (%0d,%0d)", k, cap1[k], cap2[k], e1, e2);
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_rel != 2 + TOTAL + 10) begin
            n_fail++;
            $display("FAIL hold_done: got count=%0d at=%0d want 1 at %0d", done_cnt, done_rel, 2 + TOTAL + 10);
        end
    endtask

    task automatic test_load_gaps();
        int e1, e2;
        for (int j = 0; j < N; j++) ld_val[j] = int'($urandom_range(0, 4095));
        run_job(1'b0, 1, 1, -1, -1, -1);
        n_checks++;
        if (hs_cnt != N) begin n_fail++; $display("FAIL gaps_handshakes: got %0d want %0d", hs_cnt, N); end
        for (int k = 0; k < HALF; k++) begin
            e1 = red(ld_val[k]);
            e2 = red(ld_val[k + HALF]);
            n_checks++;
            if (cap1[k] != e1 || cap2[k] != e2) begin
                n_fail++;
                $display("FAIL gaps_pair[%0d]: got (%0d,%0d) want (%0d,%0d)", k, cap1[k], cap2[k], e1, e2);
            end
        end
        n_checks++;
        if (done_cnt != 1 || late_busy != 0 || en_cnt != TOTAL) begin
            n_fail++;
            $display("FAIL gaps_single_job: got done=%0d late_busy=%0d en=%0d want 1 0 %0d", done_cnt, late_busy, en_cnt, TOTAL);
        end
    endtask

    task automatic test_reset_mid_stream();
        int e1, e2;
        int late_done;
        for (int j = 0; j < N; j++) ld_val[j] = j;
        run_job(1'b0, 0, 0, -1, -1, 60);
        in_valid = 1'b0; pipe_hold = 1'b0; start = 1'b0;
        n_checks++;
        if (ab_hit != 1) begin n_fail++; $display("FAIL abort_reached: got %0d want 1", ab_hit); end
        n_checks++;
        if ({ab_en, ab_busy, ab_done, ab_rdy} !== 4'b0 || ab_o1 !== '0 || ab_o2 !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got en/busy/done/rdy=%b o=(%0d,%0d) want 0000 (0,0)",
                     {ab_en, ab_busy, ab_done, ab_rdy}, ab_o1, ab_o2);
        end
        late_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) late_done++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) late_done++;
        end
        n_checks++;
        if (late_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", late_done); end
        run_job(1'b1, 0, 0, -1, -1, -1);
        for (int k = 0; k < HALF; k++) begin
            e1 = 2 * k;
            e2 = 2 * k + 1;
            n_checks++;
            if (cap1[k] != e1 || cap2[k] != e2) begin
                n_fail++;
                $display("FAIL rerun_pair[%0d]: got (%0d,%0d) want (%0d,%0d)", k, cap1[k], cap2[k], e1, e2);
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_rel != 2 + TOTAL || en_cnt != TOTAL) begin
            n_fail++;
            $display("FAIL rerun_done: got count=%0d at=%0d en=%0d want 1 at %0d en %0d",
                     done_cnt, done_rel, en_cnt, 2 + TOTAL, TOTAL);
        end
    endtask

    initial begin
        test_reset();
        test_ntt_order();
        test_intt_order();
        test_reduction();
        test_hold();
        test_load_gaps();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
